// File: rtl/uart_pkg.sv
// Shared definitions for the AGV sensor-link UART receiver.
package uart_pkg;

    // Receiver FSM states
    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_START = 2'd1,
        ST_DATA  = 2'd2,
        ST_STOP  = 2'd3
    } rx_state_t;

    localparam int FRAME_BYTES = 6;
    localparam int BYTE_W      = 8;
    localparam int FRAME_W     = FRAME_BYTES * BYTE_W;
    localparam int IDX_W       = 3;

    // Counter width that can hold 0..n-1 (never narrower than one bit)
    function automatic int cnt_width(input int n);
        return (n <= 2) ? 1 : $clog2(n);
    endfunction

endpackage

// File: rtl/uart_byte_rx.sv
// Single-byte 8N1 receiver: input synchronizer, mid-bit sampling FSM and bit counter.
// Emits byte_done or stop_err for one cycle after the stop-bit midpoint.
module uart_byte_rx
    import uart_pkg::*;
#(
    parameter int CLKS_PER_BIT = 87
) (
    input  logic              clk,
    input  logic              reset_n,
    input  logic              rx,
    output logic [BYTE_W-1:0] byte_data,
    output logic              byte_done,
    output logic              stop_err,
    output logic              active
);

    localparam int CW = cnt_width(CLKS_PER_BIT);
    localparam logic [CW-1:0] HALF_C = CW'(CLKS_PER_BIT / 2);
    localparam logic [CW-1:0] LAST_C = CW'(CLKS_PER_BIT - 1);

    logic              sync1_reg;
    logic              rx_s;
    rx_state_t         state_reg,   state_next;
    logic [CW-1:0]     cnt_reg,     cnt_next;
    logic [2:0]        bit_idx_reg, bit_idx_next;
    logic [BYTE_W-1:0] shift_reg,   shift_next;
    logic              armed_reg,   armed_next;
    logic              done_reg,    done_next;
    logic              err_reg,     err_next;

    // Two-flop synchronizer; line idles high so reset value is 1
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            sync1_reg <= 1'b1;
            rx_s      <= 1'b1;
        end else begin
            sync1_reg <= rx;
            rx_s      <= sync1_reg;
        end
    end

    // FSM state, counters, data shift register and strobes
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_reg   <= ST_IDLE;
            cnt_reg     <= '0;
            bit_idx_reg <= '0;
            shift_reg   <= '0;
            armed_reg   <= 1'b1;
            done_reg    <= 1'b0;
            err_reg     <= 1'b0;
        end else begin
            state_reg   <= state_next;
            cnt_reg     <= cnt_next;
            bit_idx_reg <= bit_idx_next;
            shift_reg   <= shift_next;
            armed_reg   <= armed_next;
            done_reg    <= done_next;
            err_reg     <= err_next;
        end
    end

    // Next-state logic: start edge detect, mid-bit sampling, stop check
    always_comb begin
        state_next   = state_reg;
        cnt_next     = cnt_reg + 1'b1;
        bit_idx_next = bit_idx_reg;
        shift_next   = shift_reg;
        armed_next   = armed_reg;
        done_next    = 1'b0;
        err_next     = 1'b0;

        case (state_reg)
            ST_IDLE: begin
                cnt_next = '0;
                // After a break the line must go high again before a new start is accepted
                if (rx_s) begin
                    armed_next = 1'b1;
                end else if (armed_reg) begin
                    state_next = ST_START;
                end
            end
            ST_START: begin
                if (cnt_reg == HALF_C) begin
                    cnt_next = '0;
                    if (rx_s) begin
                        state_next = ST_IDLE;
                    end else begin
                        state_next   = ST_DATA;
                        bit_idx_next = '0;
                    end
                end
            end
            ST_DATA: begin
                // Counter was re-centred at mid start bit, so LAST_C lands on mid data bit
                if (cnt_reg == LAST_C) begin
                    cnt_next                = '0;
                    shift_next[bit_idx_reg] = rx_s;
                    if (bit_idx_reg == 3'd7) begin
                        state_next = ST_STOP;
                    end else begin
                        bit_idx_next = bit_idx_reg + 3'd1;
                    end
                end
            end
            ST_STOP: begin
                // Leave at mid stop bit so the next start edge is never missed
                if (cnt_reg == LAST_C) begin
                    cnt_next   = '0;
                    state_next = ST_IDLE;
                    if (rx_s) begin
                        done_next = 1'b1;
                    end else begin
                        err_next   = 1'b1;
                        armed_next = 1'b0;
                    end
                end
            end
            default: begin
                state_next = ST_IDLE;
                cnt_next   = '0;
            end
        endcase
    end

    assign byte_data = shift_reg;
    assign byte_done = done_reg;
    assign stop_err  = err_reg;
    assign active    = (state_reg != ST_IDLE);

endmodule

// File: rtl/uart_frame_rx.sv
// Six-byte frame receiver: collects bytes from uart_byte_rx into a frame,
// resyncs on inter-byte timeout, and publishes the three 16-bit words.
module uart_frame_rx
    import uart_pkg::*;
#(
    parameter int CLKS_PER_BIT = 87,
    parameter int TIMEOUT_BITS = 20
) (
    input  logic        clk,
    input  logic        reset_n,
    input  logic        Rx,
    output logic [15:0] max_distance_angle,
    output logic [15:0] min_distance_angle,
    output logic [15:0] obs_alert,
    output logic        frame_valid,
    output logic        frame_error,
    output logic        busy
);

    localparam int GAP_LIMIT = TIMEOUT_BITS * CLKS_PER_BIT;
    localparam int GW        = $clog2(GAP_LIMIT + 1);
    localparam logic [GW-1:0]    GAP_LAST_C = GW'(GAP_LIMIT - 1);
    localparam logic [IDX_W-1:0] LAST_IDX_C = IDX_W'(FRAME_BYTES - 1);

    logic [BYTE_W-1:0]  byte_data;
    logic               byte_done;
    logic               stop_err;
    logic               rx_active;

    logic [IDX_W-1:0]   byte_idx_reg;
    logic [GW-1:0]      gap_reg;
    logic               timeout_hit;
    logic [BYTE_W-1:0]  slot_reg [FRAME_BYTES-1];
    logic [FRAME_W-1:0] frame_w;
    logic [15:0]        max_reg, min_reg, obs_reg;
    logic               valid_reg, error_reg;

    uart_byte_rx #(
        .CLKS_PER_BIT(CLKS_PER_BIT)
    ) u_byte_rx (
        .clk      (clk),
        .reset_n  (reset_n),
        .rx       (Rx),
        .byte_data(byte_data),
        .byte_done(byte_done),
        .stop_err (stop_err),
        .active   (rx_active)
    );

    // Slots 0..4 are stored; the last byte is taken straight from the receiver
    genvar gi;
    generate
        for (gi = 0; gi < FRAME_BYTES - 1; gi++) begin : g_slot
            // Capture a good byte into its slot
            always_ff @(posedge clk or negedge reset_n) begin
                if (!reset_n) begin
                    slot_reg[gi] <= '0;
                end else if (byte_done && (byte_idx_reg == IDX_W'(gi))) begin
                    slot_reg[gi] <= byte_data;
                end
            end
            assign frame_w[gi*BYTE_W +: BYTE_W] = slot_reg[gi];
        end
    endgenerate
    assign frame_w[FRAME_W-1 -: BYTE_W] = byte_data;

    assign timeout_hit = !rx_active && (byte_idx_reg != '0) && (gap_reg == GAP_LAST_C);

    // Inter-byte gap counter: runs only while idle inside a partial frame
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            gap_reg <= '0;
        end else if (rx_active || (byte_idx_reg == '0) || byte_done || stop_err || timeout_hit) begin
            gap_reg <= '0;
        end else begin
            gap_reg <= gap_reg + 1'b1;
        end
    end

    // Byte index, frame publication and error strobe
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            byte_idx_reg <= '0;
            max_reg      <= '0;
            min_reg      <= '0;
            obs_reg      <= '0;
            valid_reg    <= 1'b0;
            error_reg    <= 1'b0;
        end else begin
            valid_reg <= 1'b0;
            error_reg <= 1'b0;
            if (stop_err) begin
                error_reg    <= 1'b1;
                byte_idx_reg <= '0;
            end else if (byte_done) begin
                if (byte_idx_reg == LAST_IDX_C) begin
                    max_reg      <= frame_w[15:0];
                    min_reg      <= frame_w[31:16];
                    obs_reg      <= frame_w[47:32];
                    valid_reg    <= 1'b1;
                    byte_idx_reg <= '0;
                end else begin
                    byte_idx_reg <= byte_idx_reg + 1'b1;
                end
            end else if (timeout_hit) begin
                byte_idx_reg <= '0;
            end
        end
    end

    assign max_distance_angle = max_reg;
    assign min_distance_angle = min_reg;
    assign obs_alert          = obs_reg;
    assign frame_valid        = valid_reg;
    assign frame_error        = error_reg;
    assign busy               = rx_active || (byte_idx_reg != '0);

endmodule

// File: tb/tb_uart_frame_rx.sv
// Bench for uart_frame_rx: serial line model, frame scoreboard, table of frames
// plus hand-written glitch, timeout, break and reset sequences.
module tb_uart_frame_rx;

    localparam int CPB = 87;
    localparam int TOB = 20;

    logic        clk = 1'b0;
    logic        reset_n = 1'b0;
    logic        Rx = 1'b1;
    logic [15:0] max_distance_angle;
    logic [15:0] min_distance_angle;
    logic [15:0] obs_alert;
    logic        frame_valid;
    logic        frame_error;
    logic        busy;

    always #5 clk = ~clk;

    uart_frame_rx #(
        .CLKS_PER_BIT(CPB),
        .TIMEOUT_BITS(TOB)
    ) dut (
        .clk               (clk),
        .reset_n           (reset_n),
        .Rx                (Rx),
        .max_distance_angle(max_distance_angle),
        .min_distance_angle(min_distance_angle),
        .obs_alert         (obs_alert),
        .frame_valid       (frame_valid),
        .frame_error       (frame_error),
        .busy              (busy)
    );

    typedef struct {
        logic [15:0] mx;
        logic [15:0] mn;
        logic [15:0] ob;
    } frame_t;

    typedef struct {
        frame_t f;
        int     bad_idx;   // 6 = every stop bit good
        int     gap;       // idle bit-times after the frame
        bit     exp_valid;
        bit     exp_err;
    } vec_t;

    frame_t      sb[$];
    frame_t      popped;
    int          total = 0;
    int          bad = 0;
    int          valid_cnt = 0;
    int          err_cnt = 0;
    int          exp_v = 0;
    int          exp_e = 0;
    logic [47:0] held_w = '0;
    logic [47:0] prev_out = '0;
    bit          prev_ok = 1'b0;

    task automatic check(input string name, input logic [47:0] got, input logic [47:0] want);
        total++;
        if (got !== want) begin
            bad++;
            $display("FAIL %s got=%h want=%h", name, got, want);
        end else begin
            $display("ok   %s = %h", name, got);
        end
    endtask

    // Output monitor: scoreboard pop on each frame_valid, exclusivity and hold checks
    always @(negedge clk) begin
        if (reset_n) begin
            if (frame_valid || frame_error)
                check("valid_err_exclusive", {47'd0, frame_valid & frame_error}, 48'd0);
            if (frame_valid) begin
                valid_cnt++;
                if (sb.size() == 0) begin
                    total++;
                    bad++;
                    $display("FAIL unexpected_frame_valid got=%h want=none",
                             {obs_alert, min_distance_angle, max_distance_angle});
                end else begin
                    popped = sb.pop_front();
                    check("frame_words", {obs_alert, min_distance_angle, max_distance_angle},
                          {popped.ob, popped.mn, popped.mx});
                    held_w = {popped.ob, popped.mn, popped.mx};
                end
            end
            if (frame_error) err_cnt++;
            if (prev_ok && !frame_valid &&
                ({obs_alert, min_distance_angle, max_distance_angle} !== prev_out))
                check("hold_outputs", {obs_alert, min_distance_angle, max_distance_angle}, prev_out);
        end
        prev_out = {obs_alert, min_distance_angle, max_distance_angle};
        prev_ok  = reset_n;
    end

    task automatic line_bit(input logic v);
        Rx = v;
        repeat (CPB) @(posedge clk);
        #1;
    endtask

    task automatic send_byte(input logic [7:0] d, input logic stop);
        line_bit(1'b0);
        for (int i = 0; i < 8; i++) line_bit(d[i]);
        line_bit(stop);
    endtask

    task automatic idle_bits(input int n);
        Rx = 1'b1;
        repeat (n * CPB) @(posedge clk);
        #1;
    endtask

    // Send bytes 0..nbytes-1 of a frame; byte bad_idx gets a zero stop bit
    task automatic send_frame(input frame_t f, input int bad_idx, input int nbytes);
        logic [47:0] fb;
        fb = {f.ob, f.mn, f.mx};
        for (int i = 0; i < nbytes; i++)
            send_byte(fb[i*8 +: 8], (i == bad_idx) ? 1'b0 : 1'b1);
        Rx = 1'b1;
    endtask

    vec_t   vecs[4];
    frame_t fr;

    initial begin
        vecs[0] = '{f:'{16'h1234, 16'hABCD, 16'h0001}, bad_idx:6, gap:0, exp_valid:1'b1, exp_err:1'b0};
        vecs[1] = '{f:'{16'hFFFF, 16'h0000, 16'h8001}, bad_idx:6, gap:2, exp_valid:1'b1, exp_err:1'b0};
        vecs[2] = '{f:'{16'hDEAD, 16'hBEEF, 16'hCAFE}, bad_idx:3, gap:2, exp_valid:1'b0, exp_err:1'b1};
        vecs[3] = '{f:'{16'h0102, 16'h0304, 16'h0506}, bad_idx:6, gap:2, exp_valid:1'b1, exp_err:1'b0};

        // Reset state
        repeat (3) @(posedge clk);
        #1;
        check("reset_words", {obs_alert, min_distance_angle, max_distance_angle}, 48'd0);
        check("reset_valid", {47'd0, frame_valid}, 48'd0);
        check("reset_error", {47'd0, frame_error}, 48'd0);
        check("reset_busy", {47'd0, busy}, 48'd0);
        @(posedge clk);
        #1;
        reset_n = 1'b1;
        idle_bits(2);

        // Table of frames; entries 0 and 1 go back-to-back
        for (int i = 0; i < 4; i++) begin
            if (vecs[i].exp_valid) sb.push_back(vecs[i].f);
            send_frame(vecs[i].f, vecs[i].bad_idx,
                       (vecs[i].bad_idx == 6) ? 6 : vecs[i].bad_idx + 1);
            exp_v += int'(vecs[i].exp_valid);
            exp_e += int'(vecs[i].exp_err);
            idle_bits(vecs[i].gap);
            check($sformatf("vec%0d_valid_count", i), 48'(valid_cnt), 48'(exp_v));
            check($sformatf("vec%0d_error_count", i), 48'(err_cnt), 48'(exp_e));
            check($sformatf("vec%0d_busy", i), {47'd0, busy}, 48'd0);
        end

        // Glitch: 30 clk low in IDLE
        Rx = 1'b0;
        repeat (10) @(posedge clk);
        #1;
        check("glitch_busy_high", {47'd0, busy}, 48'd1);
        repeat (20) @(posedge clk);
        #1;
        idle_bits(2);
        check("glitch_busy_low", {47'd0, busy}, 48'd0);
        check("glitch_valid_count", 48'(valid_cnt), 48'(exp_v));
        check("glitch_error_count", 48'(err_cnt), 48'(exp_e));
        check("glitch_words", {obs_alert, min_distance_angle, max_distance_angle}, held_w);

        // Timeout: 3 bytes, 25 idle bit-times, then a full frame
        fr = '{16'h5555, 16'h6666, 16'h7777};
        send_frame(fr, 6, 3);
        idle_bits(TOB + 5);
        check("timeout_busy", {47'd0, busy}, 48'd0);
        fr = '{16'h0A0B, 16'h0C0D, 16'h0E0F};
        sb.push_back(fr);
        send_frame(fr, 6, 6);
        exp_v++;
        idle_bits(2);
        check("timeout_valid_count", 48'(valid_cnt), 48'(exp_v));
        check("timeout_error_count", 48'(err_cnt), 48'(exp_e));

        // Break: line held low for 12 bit-times gives exactly one error
        Rx = 1'b0;
        repeat (12 * CPB) @(posedge clk);
        #1;
        exp_e++;
        check("break_error_count", 48'(err_cnt), 48'(exp_e));
        idle_bits(2);
        check("break_error_after_release", 48'(err_cnt), 48'(exp_e));
        check("break_busy", {47'd0, busy}, 48'd0);

        // Reset during byte 4
        fr = '{16'h1111, 16'h2222, 16'h3333};
        send_frame(fr, 6, 4);
        line_bit(1'b0);
        for (int i = 0; i < 3; i++) line_bit(1'b1);
        reset_n = 1'b0;
        #1;
        check("midreset_words", {obs_alert, min_distance_angle, max_distance_angle}, 48'd0);
        check("midreset_busy", {47'd0, busy}, 48'd0);
        held_w = '0;
        Rx = 1'b1;
        @(posedge clk);
        #1;
        reset_n = 1'b1;
        idle_bits(2);
        check("midreset_no_pulse", 48'(valid_cnt), 48'(exp_v));
        fr = '{16'h4242, 16'h1357, 16'h9BDF};
        sb.push_back(fr);
        send_frame(fr, 6, 6);
        exp_v++;
        idle_bits(2);
        check("post_reset_valid_count", 48'(valid_cnt), 48'(exp_v));
        check("post_reset_words", {obs_alert, min_distance_angle, max_distance_angle},
              {16'h9BDF, 16'h1357, 16'h4242});
        check("final_error_count", 48'(err_cnt), 48'(exp_e));
        check("scoreboard_empty", 48'(sb.size()), 48'd0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
